// File: rtl/os_input_buf_pkg.sv
// Shared types and helpers for the oversampled PFB input buffer.
package os_input_buf_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    FILL,
    EMIT
  } state_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/os_input_buf_if.sv
// AXI-Stream style sample bus (tdata/tvalid/tready).
interface os_input_buf_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/os_input_buf_sdp_ram.sv
// Simple dual-port RAM, one write port and one read port with a registered read.
module sdp_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/os_input_buf.sv
// Input frame buffer for an oversampled PFB: accepts DEC_FAC new samples per
// frame and emits the FFT_LEN newest samples, newest first.
module os_input_buf
  import os_input_buf_pkg::*;
#(
  parameter int unsigned FFT_LEN     = 32,
  parameter int unsigned DEC_FAC     = 24,
  parameter int unsigned TDATA_WIDTH = 16
) (
  input  logic          clkb,
  input  logic          rst,
  os_input_buf_if.slave  s_axis,
  os_input_buf_if.master m_axis,
  output logic          m_axis_tlast,
  output logic [15:0]   frame_cnt,
  output logic          busy
);

  localparam int unsigned AW = $clog2(FFT_LEN);
  localparam int unsigned CW = $clog2(FFT_LEN + 1);
  localparam int unsigned DW = 2 * TDATA_WIDTH;

  if (DEC_FAC < 1 || DEC_FAC > FFT_LEN || FFT_LEN < 2 || !is_pow2(FFT_LEN)) begin : g_bad_params
    $error("os_input_buf: need FFT_LEN power of 2 (>=2) and 1 <= DEC_FAC <= FFT_LEN");
  end

  state_t        state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] clr_addr;
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] iss;
  logic          rd_vld;
  logic          rd_last;
  logic          s_ready_q;
  logic          m_valid_q;
  logic [DW-1:0] m_data_q;

  logic          accept;
  logic          out_adv;
  logic          rd_en;
  logic          issue;
  logic          last_hs;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rd_data;

  assign s_axis.tready = s_ready_q;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;

  // Two-stage read pipeline (RAM output register, then output register); each
  // stage advances when the stage after it can take data or it is empty.
  always_comb begin
    accept    = (state == FILL) && s_ready_q && s_axis.tvalid;
    out_adv   = !m_valid_q || m_axis.tready;
    rd_en     = (state == EMIT) && (!rd_vld || out_adv);
    issue     = rd_en && (iss < CW'(FFT_LEN));
    last_hs   = m_valid_q && m_axis.tready && m_axis_tlast;
    raddr     = wptr - AW'(1) - iss[AW-1:0];
    ram_we    = !rst && ((state == CLEAR) || accept);
    ram_waddr = (state == CLEAR) ? clr_addr : wptr;
    ram_wdata = (state == CLEAR) ? '0 : s_axis.tdata;
  end

  sdp_ram #(
    .DEPTH(FFT_LEN),
    .WIDTH(DW)
  ) u_ram (
    .clk  (clkb),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (rd_en),
    .raddr(raddr),
    .rdata(rd_data)
  );

  always_ff @(posedge clkb) begin
    if (rst) begin
      state        <= CLEAR;
      wptr         <= '0;
      clr_addr     <= '0;
      fill_cnt     <= '0;
      iss          <= '0;
      rd_vld       <= 1'b0;
      rd_last      <= 1'b0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_data_q     <= '0;
      frame_cnt    <= '0;
      busy         <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + AW'(1);
          if (clr_addr == AW'(FFT_LEN - 1)) begin
            state     <= FILL;
            s_ready_q <= 1'b1;
            busy      <= 1'b0;
          end
        end
        FILL: begin
          if (accept) begin
            wptr <= wptr + AW'(1);
            if (fill_cnt == CW'(DEC_FAC - 1)) begin
              fill_cnt  <= '0;
              iss       <= '0;
              state     <= EMIT;
              s_ready_q <= 1'b0;
              busy      <= 1'b1;
            end else begin
              fill_cnt <= fill_cnt + CW'(1);
            end
          end
        end
        EMIT: begin
          if (rd_en) begin
            rd_vld  <= issue;
            rd_last <= (iss == CW'(FFT_LEN - 1));
            if (issue) iss <= iss + CW'(1);
          end
          if (out_adv) begin
            m_valid_q    <= rd_vld;
            m_axis_tlast <= rd_vld && rd_last;
            if (rd_vld) m_data_q <= rd_data;
          end
          if (last_hs) begin
            frame_cnt    <= frame_cnt + 16'd1;
            state        <= FILL;
            s_ready_q    <= 1'b1;
            busy         <= 1'b0;
            m_valid_q    <= 1'b0;
            m_axis_tlast <= 1'b0;
            rd_vld       <= 1'b0;
            iss          <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
